// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: SPI scan controller for an 8-channel 12-bit serial ADC
// (16-clock frames, 3-bit address on DIN, previous channel's result on DOUT).
//
// Ports:
//   iCLK, iRST      clock (rising edge), async active-low reset
//   iSTART, iCONT   single-shot request / continuous rescan enable
//   iCH_MASK        channel enables, latched when a scan starts
//   oSCLK, oCS_n    ADC serial clock (idles high) and chip select
//   oDIN, iDOUT     ADC address line and serial result line
//   oDATA           NUM_CH result slots of OUT_W bits (MSBs of each sample)
//   oVALID, oCH     one-cycle slot-write strobe and the channel written
//   oBUSY, oDONE    scan in progress / end-of-scan pulse
module adc_scan_ctrl #(
    parameter int NUM_CH  = 8,
    parameter int OUT_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iSTART,
    input  logic                    iCONT,
    input  logic [NUM_CH-1:0]       iCH_MASK,
    output logic                    oSCLK,
    output logic                    oCS_n,
    output logic                    oDIN,
    input  logic                    iDOUT,
    output logic [NUM_CH*OUT_W-1:0] oDATA,
    output logic                    oVALID,
    output logic [2:0]              oCH,
    output logic                    oBUSY,
    output logic                    oDONE
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t            state;
    logic [DW-1:0]     divCnt;
    logic [3:0]        bitCnt;
    logic [11:0]       sr;
    logic [NUM_CH-1:0] pending;
    logic [2:0]        firstCh;
    logic [2:0]        addrCh;
    logic [2:0]        prevCh;
    logic              firstFrame;
    logic              finalFrame;
    logic [OUT_W-1:0]  slot [NUM_CH];

    logic       launch;
    logic       wrSlot;
    logic       dinNext;
    logic [3:0] nextBit;
    logic [2:0] startCh;
    logic [2:0] nextCh;

    function automatic logic [2:0] lowCh(input logic [NUM_CH-1:0] m);
        logic [2:0] c;
        c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) c = 3'(i);
        return c;
    endfunction

    // Clears the lowest set bit: the channel just addressed.
    function automatic logic [NUM_CH-1:0] clrLow(input logic [NUM_CH-1:0] m);
        return m & (m - NUM_CH'(1));
    endfunction

    assign startCh = lowCh(iCH_MASK);
    assign nextCh  = lowCh(pending);
    assign nextBit = bitCnt + 4'd1;

    // A scan starts from IDLE, or chains straight out of the last TRAIL cycle.
    assign launch = (|iCH_MASK) &&
                    (((state == IDLE) && (iSTART || iCONT)) ||
                     ((state == TRAIL) && (divCnt == DIV_LAST) && iCONT));

    // First high cycle after the 16th rising edge: the sample is complete.
    assign wrSlot = (state == SHIFT) && oSCLK && (divCnt == '0) &&
                    (bitCnt == 4'd15) && !firstFrame;

    always_comb begin
        dinNext = 1'b0;
        case (nextBit)
            4'd2:    dinNext = addrCh[2];
            4'd3:    dinNext = addrCh[1];
            4'd4:    dinNext = addrCh[0];
            default: dinNext = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= IDLE;
            divCnt     <= '0;
            bitCnt     <= '0;
            sr         <= '0;
            pending    <= '0;
            firstCh    <= '0;
            addrCh     <= '0;
            prevCh     <= '0;
            firstFrame <= 1'b0;
            finalFrame <= 1'b0;
            oSCLK      <= 1'b1;
            oCS_n      <= 1'b1;
            oDIN       <= 1'b0;
            oVALID     <= 1'b0;
            oCH        <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            oVALID <= wrSlot;
            oDONE  <= wrSlot && finalFrame;
            if (wrSlot) oCH <= prevCh;
            if (launch) begin
                state      <= LEAD;
                divCnt     <= '0;
                oCS_n      <= 1'b0;
                oSCLK      <= 1'b1;
                oBUSY      <= 1'b1;
                firstCh    <= startCh;
                addrCh     <= startCh;
                pending    <= clrLow(iCH_MASK);
                firstFrame <= 1'b1;
                finalFrame <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    LEAD: begin
                        if (divCnt == DIV_LAST) begin
                            state  <= SHIFT;
                            divCnt <= '0;
                            bitCnt <= '0;
                            oSCLK  <= 1'b0;
                            oDIN   <= 1'b0;
                        end else begin
                            divCnt <= divCnt + DW'(1);
                        end
                    end
                    SHIFT: begin
                        if (divCnt != DIV_LAST) begin
                            divCnt <= divCnt + DW'(1);
                        end else if (!oSCLK) begin
                            divCnt <= '0;
                            oSCLK  <= 1'b1;
                            sr     <= {sr[10:0], iDOUT};
                        end else if (bitCnt != 4'd15) begin
                            divCnt <= '0;
                            bitCnt <= nextBit;
                            oSCLK  <= 1'b0;
                            oDIN   <= dinNext;
                        end else if (finalFrame) begin
                            divCnt <= '0;
                            state  <= TRAIL;
                            oCS_n  <= 1'b1;
                        end else begin
                            // Next frame: the channel just addressed
                            // becomes the one whose result comes back.
                            divCnt     <= '0;
                            bitCnt     <= '0;
                            oSCLK      <= 1'b0;
                            oDIN       <= 1'b0;
                            firstFrame <= 1'b0;
                            prevCh     <= addrCh;
                            if (|pending) begin
                                addrCh  <= nextCh;
                                pending <= clrLow(pending);
                            end else begin
                                addrCh     <= firstCh;
                                finalFrame <= 1'b1;
                            end
                        end
                    end
                    TRAIL: begin
                        if (divCnt == DIV_LAST) begin
                            divCnt <= '0;
                            state  <= IDLE;
                            oBUSY  <= 1'b0;
                        end else begin
                            divCnt <= divCnt + DW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < NUM_CH; i++) slot[i] <= '0;
        end else if (wrSlot) begin
            for (int i = 0; i < NUM_CH; i++)
                if (prevCh == 3'(i)) slot[i] <= sr[11 -: OUT_W];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gSlot
        assign oDATA[g*OUT_W +: OUT_W] = slot[g];
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with a behavioural
// ADC (DOUT on SCLK fall, DIN latched on SCLK rise, result = previous address).
module tb_adc_scan_ctrl;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       iCONT  = 1'b0;
    logic [7:0] iCH_MASK = 8'h00;

    logic        sclk1, cs1, din1, v1, busy1, done1;
    logic        dout1 = 1'b0;
    logic [2:0]  ch1;
    logic [63:0] data1;
    logic        sclk2, cs2, din2, v2, busy2, done2;
    logic        dout2 = 1'b0;
    logic [2:0]  ch2;
    logic [95:0] data2;

    adc_scan_ctrl #(.NUM_CH(8), .OUT_W(8), .CLK_DIV(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(start1), .iCONT(iCONT),
        .iCH_MASK(iCH_MASK), .oSCLK(sclk1), .oCS_n(cs1), .oDIN(din1),
        .iDOUT(dout1), .oDATA(data1), .oVALID(v1), .oCH(ch1),
        .oBUSY(busy1), .oDONE(done1)
    );

    adc_scan_ctrl #(.NUM_CH(8), .OUT_W(12), .CLK_DIV(1)) dut2 (
        .iCLK(iCLK), .iRST(iRST), .iSTART(start2), .iCONT(1'b0),
        .iCH_MASK(iCH_MASK), .oSCLK(sclk2), .oCS_n(cs2), .oDIN(din2),
        .iDOUT(dout2), .oDATA(data2), .oVALID(v2), .oCH(ch2),
        .oBUSY(busy2), .oDONE(done2)
    );

    int nCmp = 0;
    int nBad = 0;
    int modelMode = 0;

    function automatic logic [11:0] adcVal(input logic [2:0] ch);
        if (modelMode == 0) return 12'hABC;
        return {1'b0, ch, 8'h23};
    endfunction

    // ADC models
    int         bit1, bit2;
    logic [2:0] addr1, prev1, addr2, prev2;
    logic [2:0] log1[$];
    logic [2:0] log2[$];

    always @(negedge cs1) begin bit1 = 0; prev1 = 3'd0; end
    always @(negedge sclk1) if (!cs1) begin
        logic [11:0] w;
        w = adcVal(prev1);
        dout1 = (bit1 < 4) ? 1'b0 : w[15-bit1];
    end
    always @(posedge sclk1) if (!cs1) begin
        if (bit1 >= 2 && bit1 <= 4) addr1[4-bit1] = din1;
        if (bit1 == 15) begin
            log1.push_back(addr1); prev1 = addr1; bit1 = 0;
        end else bit1++;
    end

    always @(negedge cs2) begin bit2 = 0; prev2 = 3'd0; end
    always @(negedge sclk2) if (!cs2) begin
        logic [11:0] w;
        w = adcVal(prev2);
        dout2 = (bit2 < 4) ? 1'b0 : w[15-bit2];
    end
    always @(posedge sclk2) if (!cs2) begin
        if (bit2 >= 2 && bit2 <= 4) addr2[4-bit2] = din2;
        if (bit2 == 15) begin
            log2.push_back(addr2); prev2 = addr2; bit2 = 0;
        end else bit2++;
    end

    // Per-run observations
    int csFallK, csLowN, csFalls, busyN, csHiBusyN;
    int sclkFallK, sclkLowN, vN, doneN, doneVN;
    int vKq[$];
    int vChq[$];

    task automatic observe(input bit sel, input bit useCont, input int maxK,
                           input int dropK, input int pulseK, input int maskK,
                           input logic [7:0] newMask);
        logic cs, sclk, busy, v, dn, prevCs;
        logic [2:0] ch;
        csFallK = -1; csLowN = 0; csFalls = 0; busyN = 0; csHiBusyN = 0;
        sclkFallK = -1; sclkLowN = 0; vN = 0; doneN = 0; doneVN = 0;
        vKq.delete(); vChq.delete(); log1.delete(); log2.delete();
        prevCs = 1'b1;
        @(negedge iCLK);
        if (useCont) iCONT = 1'b1;
        else if (sel) start2 = 1'b1;
        else start1 = 1'b1;
        for (int k = 1; k <= maxK; k++) begin
            @(negedge iCLK);
            if (k == 1) begin start1 = 1'b0; start2 = 1'b0; end
            if (k == dropK) iCONT = 1'b0;
            if (k == pulseK) start1 = 1'b1;
            if (k == pulseK + 1) start1 = 1'b0;
            if (k == maskK) iCH_MASK = newMask;
            cs   = sel ? cs2 : cs1;
            sclk = sel ? sclk2 : sclk1;
            busy = sel ? busy2 : busy1;
            v    = sel ? v2 : v1;
            dn   = sel ? done2 : done1;
            ch   = sel ? ch2 : ch1;
            if (!cs) begin
                csLowN++;
                if (csFallK < 0) csFallK = k;
                if (prevCs) csFalls++;
            end
            prevCs = cs;
            if (busy) busyN++;
            if (busy && cs) csHiBusyN++;
            if (!sclk) begin
                sclkLowN++;
                if (sclkFallK < 0) sclkFallK = k;
            end
            if (v) begin vN++; vKq.push_back(k); vChq.push_back(int'(ch)); end
            if (dn) doneN++;
            if (dn && v) doneVN++;
        end
    endtask

    task automatic test_reset();
        #1 iRST = 1'b0;
        #1;
        nCmp++;
        if ({sclk1, cs1, din1, v1, ch1, busy1, done1} !== 9'b1_1_0_0_000_0_0) begin
            nBad++;
            $display("FAIL reset_ctl got %b want 110000000",
                     {sclk1, cs1, din1, v1, ch1, busy1, done1});
        end
        nCmp++;
        if (data1 !== 64'h0 || data2 !== 96'h0) begin
            nBad++; $display("FAIL reset_data got %h %h want 0", data1, data2);
        end
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_single();
        modelMode = 0; iCH_MASK = 8'h01;
        observe(1'b0, 1'b0, 400, -1, -1, -1, 8'h00);
        nCmp++;
        if (csFallK !== 1) begin nBad++; $display("FAIL single_csfall got %0d want 1", csFallK); end
        nCmp++;
        if (sclkFallK !== 5) begin nBad++; $display("FAIL single_sclkfall got %0d want 5", sclkFallK); end
        nCmp++;
        if (csLowN !== 260) begin nBad++; $display("FAIL single_cslow got %0d want 260", csLowN); end
        nCmp++;
        if (busyN !== 264) begin nBad++; $display("FAIL single_busy got %0d want 264", busyN); end
        nCmp++;
        if (vN !== 1 || vKq[0] !== 258 || vChq[0] !== 0) begin
            nBad++; $display("FAIL single_valid got n=%0d k=%0d ch=%0d want 1/258/0", vN, vKq[0], vChq[0]);
        end
        nCmp++;
        if (doneN !== 1 || doneVN !== 1) begin
            nBad++; $display("FAIL single_done got %0d/%0d want 1/1", doneN, doneVN);
        end
        nCmp++;
        if (data1 !== 64'h0000_0000_0000_00AB) begin
            nBad++; $display("FAIL single_data got %h want ab", data1);
        end
        nCmp++;
        if (log1.size() != 2 || log1[0] !== 3'd0 || log1[1] !== 3'd0) begin
            nBad++; $display("FAIL single_addr got n=%0d want 2 frames addr 0", log1.size());
        end
    endtask

    task automatic test_multi();
        modelMode = 1; iCH_MASK = 8'h05;
        observe(1'b0, 1'b0, 500, -1, -1, -1, 8'h00);
        nCmp++;
        if (vN !== 2 || vChq[0] !== 0 || vChq[1] !== 2) begin
            nBad++; $display("FAIL multi_ch got n=%0d %0d,%0d want 2 0,2", vN, vChq[0], vChq[1]);
        end
        nCmp++;
        if (vKq[1] !== 386) begin nBad++; $display("FAIL multi_vk got %0d want 386", vKq[1]); end
        nCmp++;
        if (data1 !== 64'h0000_0000_0022_0002) begin
            nBad++; $display("FAIL multi_data got %h want 220002", data1);
        end
        nCmp++;
        if (log1.size() != 3 || log1[0] !== 3'd0 || log1[1] !== 3'd2 || log1[2] !== 3'd0) begin
            nBad++; $display("FAIL multi_addr got n=%0d want 0,2,0", log1.size());
        end
        nCmp++;
        if (busyN !== 392 || doneN !== 1) begin
            nBad++; $display("FAIL multi_len got %0d/%0d want 392/1", busyN, doneN);
        end
    endtask

    task automatic test_out12();
        modelMode = 1; iCH_MASK = 8'h80;
        observe(1'b1, 1'b0, 200, -1, -1, -1, 8'h00);
        nCmp++;
        if (sclkFallK !== 2) begin nBad++; $display("FAIL out12_sclkfall got %0d want 2", sclkFallK); end
        nCmp++;
        if (csLowN !== 65 || sclkLowN !== 32) begin
            nBad++; $display("FAIL out12_timing got cs=%0d sl=%0d want 65/32", csLowN, sclkLowN);
        end
        nCmp++;
        if (vN !== 1 || vKq[0] !== 66 || vChq[0] !== 7) begin
            nBad++; $display("FAIL out12_valid got n=%0d k=%0d ch=%0d want 1/66/7", vN, vKq[0], vChq[0]);
        end
        nCmp++;
        if (data2 !== {12'h723, 84'h0}) begin
            nBad++; $display("FAIL out12_data got %h want 723 in slot7", data2);
        end
        nCmp++;
        if (log2.size() != 2 || log2[0] !== 3'd7 || log2[1] !== 3'd7) begin
            nBad++; $display("FAIL out12_addr got n=%0d want 7,7", log2.size());
        end
        nCmp++;
        if (busyN !== 66) begin nBad++; $display("FAIL out12_busy got %0d want 66", busyN); end
    endtask

    task automatic test_back_to_back();
        int err;
        modelMode = 1; iCH_MASK = 8'hFF;
        observe(1'b0, 1'b1, 2600, 1500, -1, -1, 8'h00);
        nCmp++;
        if (csFalls !== 2 || csHiBusyN !== 8) begin
            nBad++; $display("FAIL b2b_cs got falls=%0d gap=%0d want 2/8", csFalls, csHiBusyN);
        end
        nCmp++;
        if (busyN !== 2320 || doneN !== 2) begin
            nBad++; $display("FAIL b2b_len got %0d/%0d want 2320/2", busyN, doneN);
        end
        err = 0;
        for (int j = 0; j < 16; j++) if (vChq[j] !== (j % 8)) err++;
        nCmp++;
        if (vN !== 16 || err != 0) begin
            nBad++; $display("FAIL b2b_ch got n=%0d bad=%0d want 16/0", vN, err);
        end
        nCmp++;
        if (vKq[8] !== 1418) begin nBad++; $display("FAIL b2b_vk got %0d want 1418", vKq[8]); end
        nCmp++;
        if (data1 !== 64'h7262_5242_3222_1202) begin
            nBad++; $display("FAIL b2b_data got %h want 7262524232221202", data1);
        end
        err = 0;
        for (int j = 0; j < 18; j++) if (log1[j] !== 3'(((j % 9) == 8) ? 0 : (j % 9))) err++;
        nCmp++;
        if (log1.size() != 18 || err != 0) begin
            nBad++; $display("FAIL b2b_addr got n=%0d bad=%0d want 18/0", log1.size(), err);
        end
    endtask

    task automatic test_boundary();
        modelMode = 0; iCH_MASK = 8'h00;
        observe(1'b0, 1'b0, 40, -1, -1, -1, 8'h00);
        nCmp++;
        if (busyN !== 0 || csLowN !== 0) begin
            nBad++; $display("FAIL mask0 got busy=%0d cs=%0d want 0/0", busyN, csLowN);
        end
        iCH_MASK = 8'h01;
        observe(1'b0, 1'b0, 600, -1, 100, 50, 8'hFF);
        nCmp++;
        if (csFalls !== 1 || vN !== 1 || busyN !== 264) begin
            nBad++; $display("FAIL busy_start got falls=%0d v=%0d busy=%0d want 1/1/264", csFalls, vN, busyN);
        end
        nCmp++;
        if (data1 !== 64'h7262_5242_3222_12AB) begin
            nBad++; $display("FAIL hold_data got %h want 72625242322212ab", data1);
        end
    endtask

    task automatic test_reset_mid();
        modelMode = 1; iCH_MASK = 8'h05;
        @(negedge iCLK); start1 = 1'b1;
        for (int k = 1; k <= 207; k++) begin
            @(negedge iCLK);
            if (k == 1) start1 = 1'b0;
        end
        nCmp++;
        if (busy1 !== 1'b1 || sclk1 !== 1'b0) begin
            nBad++; $display("FAIL mid_prestate got busy=%b sclk=%b want 1/0", busy1, sclk1);
        end
        iRST = 1'b0;
        #1;
        nCmp++;
        if ({sclk1, cs1, din1, v1, ch1, busy1, done1} !== 9'b1_1_0_0_000_0_0) begin
            nBad++; $display("FAIL mid_reset_ctl got %b want 110000000",
                             {sclk1, cs1, din1, v1, ch1, busy1, done1});
        end
        nCmp++;
        if (data1 !== 64'h0) begin nBad++; $display("FAIL mid_reset_data got %h want 0", data1); end
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        iCH_MASK = 8'h04;
        observe(1'b0, 1'b0, 400, -1, -1, -1, 8'h00);
        nCmp++;
        if (vN !== 1 || vChq[0] !== 2 || vKq[0] !== 258) begin
            nBad++; $display("FAIL restart_valid got n=%0d ch=%0d k=%0d want 1/2/258", vN, vChq[0], vKq[0]);
        end
        nCmp++;
        if (data1 !== 64'h0000_0000_0022_0000) begin
            nBad++; $display("FAIL restart_data got %h want 220000", data1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_out12();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
